// File: rtl/ts_mux_pkg.sv
// Shared types, constants and helpers for the TS pseudo-header multiplexer.
// Covers the FSM state type, null-packet bytes, register-map offsets and reset values.
package ts_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam logic [7:0] TS_SYNC      = 8'h47;
  localparam logic [7:0] NULL_TS_HDR1 = 8'h1F;
  localparam logic [7:0] NULL_TS_HDR2 = 8'hFF;
  localparam logic [7:0] NULL_TS_HDR3 = 8'h10;
  localparam logic [7:0] NULL_STUFF   = 8'hFF;
  localparam logic [7:0] NULL_PHDR0   = 8'hFF;

  // CTRL follows the last header byte of the last source; EN_MASK follows CTRL.
  function automatic int ctrl_offset(input int n_src, input int hdr_len);
    return n_src * hdr_len;
  endfunction

  function automatic int en_mask_offset(input int n_src, input int hdr_len);
    return n_src * hdr_len + 1;
  endfunction

  function automatic logic [7:0] hdr_reset_byte(input int src, input int k);
    logic [7:0] b;
    if (k == 0) begin
      b = 8'(src);
    end else if (k == 1) begin
      b = 8'(src + 2);
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  function automatic logic [7:0] null_payload_byte(input int idx);
    logic [7:0] b;
    if (idx == 0) begin
      b = TS_SYNC;
    end else if (idx == 1) begin
      b = NULL_TS_HDR1;
    end else if (idx == 2) begin
      b = NULL_TS_HDR2;
    end else if (idx == 3) begin
      b = NULL_TS_HDR3;
    end else begin
      b = NULL_STUFF;
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping modulo N_SRC. The request vector is doubled so the wrap needs no modulo.
module rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic             valid
);

  localparam int IW = $clog2(2 * N_SRC);

  logic [2*N_SRC-1:0] req2_s;
  logic [2*N_SRC-1:0] gnt2_s;
  logic               found_s;
  logic               hit_s;
  logic [IW-1:0]      idx_s;

  assign req2_s = {req, req};

  // Scan N_SRC positions starting at ptr; only the first hit is granted.
  always_comb begin
    gnt2_s  = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx_s         = IW'(ptr) + IW'(i);
      hit_s         = !found_s && req2_s[idx_s];
      gnt2_s[idx_s] = gnt2_s[idx_s] | hit_s;
      found_s       = found_s | hit_s;
    end
  end

  assign gnt   = gnt2_s[N_SRC-1:0] | gnt2_s[2*N_SRC-1:N_SRC];
  assign valid = found_s;

endmodule

// File: rtl/ts_packet_mux.sv
// N-source TS packet multiplexer: round-robin grant, SPI-programmable pseudo-header
// prefix per source, null-packet stuffing and an optional inter-packet gap.
module ts_packet_mux
  import ts_mux_pkg::*;
#(
  parameter int         N_SRC         = 4,
  parameter int         HDR_LEN       = 4,
  parameter int         PKT_LEN       = 188,
  parameter int         SRC_LAT       = 2,
  parameter int         GAP_CYCLES    = 0,
  parameter logic [7:0] ADDR_HDR_BASE = 8'h20
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  input  logic [N_SRC-1:0]   GOT_FULL_PACKET,
  input  logic [8*N_SRC-1:0] DATA_IN,
  input  logic [7:0]         SPI_ADDRESS,
  input  logic [7:0]         SPI_DATA,
  input  logic               RISING_SS,
  output logic [N_SRC-1:0]   GIVE_ME_ONE_PACKET,
  output logic [7:0]         DATA_OUT,
  output logic               DCLK_OUT,
  output logic               D_VALID_OUT,
  output logic               P_SYNC_OUT
);

  localparam int         SW            = $clog2(N_SRC);
  localparam int         CNT_W         = $clog2(HDR_LEN + PKT_LEN + 1);
  localparam int         GAP_W         = $clog2(GAP_CYCLES + 2);
  localparam int         NHB           = N_SRC * HDR_LEN;
  localparam bit         PULSE_IN_IDLE = (SRC_LAT == HDR_LEN);
  localparam int         PULSE_CNT     = PULSE_IN_IDLE ? 0 : HDR_LEN - SRC_LAT - 1;
  localparam logic [8:0] CTRL_OFF      = 9'(ctrl_offset(N_SRC, HDR_LEN));
  localparam logic [8:0] EN_OFF        = 9'(en_mask_offset(N_SRC, HDR_LEN));

  if (SRC_LAT < 1 || SRC_LAT > HDR_LEN || N_SRC < 2 || N_SRC > 8 ||
      HDR_LEN < 1 || HDR_LEN > 16) begin : g_param_check
    $error("ts_packet_mux: SRC_LAT, N_SRC or HDR_LEN out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [SW-1:0]    grant_q, grant_d;
  logic             null_q, null_d;
  logic [7:0]       hdr_q [NHB];
  logic [7:0]       hdr_d [NHB];
  logic [7:0]       shadow_q [HDR_LEN];
  logic [7:0]       shadow_d [HDR_LEN];
  logic             null_en_q, null_en_d;
  logic [N_SRC-1:0] en_mask_q, en_mask_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic [N_SRC-1:0] give_q, give_d;

  logic [N_SRC-1:0] arb_gnt_s;
  logic             arb_valid_s;
  logic [SW-1:0]    gidx_s;
  logic [7:0]       hdr_sel_s [HDR_LEN];
  logic [7:0]       hdr_byte_s;
  logic [7:0]       src_byte_s;
  logic [7:0]       null_byte_s;
  logic [N_SRC-1:0] grant_oh_s;
  logic             wr_s;
  logic [8:0]       off_s;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .PTR_W (SW)
  ) u_arb (
    .req   (GOT_FULL_PACKET & en_mask_q),
    .ptr   (rr_q),
    .gnt   (arb_gnt_s),
    .valid (arb_valid_s)
  );

  // Data-path selects: candidate header, current header byte, granted source byte.
  always_comb begin
    gidx_s     = '0;
    src_byte_s = 8'h00;
    grant_oh_s = '0;
    hdr_byte_s = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      gidx_s        = gidx_s | (arb_gnt_s[i] ? SW'(i) : SW'(0));
      src_byte_s    = src_byte_s | ((grant_q == SW'(i)) ? DATA_IN[8*i +: 8] : 8'h00);
      grant_oh_s[i] = (grant_q == SW'(i));
    end
    for (int k = 0; k < HDR_LEN; k++) begin
      hdr_sel_s[k] = 8'h00;
      for (int s = 0; s < N_SRC; s++) begin
        hdr_sel_s[k] = hdr_sel_s[k] | ((gidx_s == SW'(s)) ? hdr_q[s*HDR_LEN + k] : 8'h00);
      end
      hdr_byte_s = hdr_byte_s | ((cnt_q == CNT_W'(k)) ? shadow_q[k] : 8'h00);
    end
    null_byte_s = null_payload_byte(int'(cnt_q) - HDR_LEN);
  end

  // SPI register writes; they touch only the live registers, never the shadow.
  always_comb begin
    wr_s  = RISING_SS && (SPI_ADDRESS >= ADDR_HDR_BASE);
    off_s = {1'b0, SPI_ADDRESS} - {1'b0, ADDR_HDR_BASE};
    for (int i = 0; i < NHB; i++) begin
      hdr_d[i] = (wr_s && off_s == 9'(i)) ? SPI_DATA : hdr_q[i];
    end
    null_en_d = (wr_s && off_s == CTRL_OFF) ? SPI_DATA[0] : null_en_q;
    en_mask_d = (wr_s && off_s == EN_OFF) ? SPI_DATA[N_SRC-1:0] : en_mask_q;
  end

  // Packet sequencer: cnt runs through header then payload without restarting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    null_d   = null_q;
    shadow_d = shadow_q;
    data_d   = 8'h00;
    valid_d  = 1'b0;
    sync_d   = 1'b0;
    give_d   = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_valid_s) begin
          state_d = ST_HEADER;
          grant_d = gidx_s;
          null_d  = 1'b0;
          rr_d    = (gidx_s == SW'(N_SRC - 1)) ? SW'(0) : gidx_s + SW'(1);
          give_d  = PULSE_IN_IDLE ? arb_gnt_s : '0;
          for (int k = 0; k < HDR_LEN; k++) begin
            shadow_d[k] = hdr_sel_s[k];
          end
        end else if (null_en_q) begin
          state_d = ST_HEADER;
          null_d  = 1'b1;
          for (int k = 0; k < HDR_LEN; k++) begin
            shadow_d[k] = (k == 0) ? NULL_PHDR0 : 8'h00;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        data_d  = hdr_byte_s;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        give_d  = (!null_q && !PULSE_IN_IDLE && cnt_q == CNT_W'(PULSE_CNT)) ? grant_oh_s : '0;
        state_d = (cnt_q == CNT_W'(HDR_LEN - 1)) ? ST_PAYLOAD : ST_HEADER;
      end
      ST_PAYLOAD: begin
        data_d  = null_q ? null_byte_s : src_byte_s;
        valid_d = 1'b1;
        sync_d  = (cnt_q == CNT_W'(HDR_LEN));
        if (cnt_q == CNT_W'(HDR_LEN + PKT_LEN - 1)) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_PAYLOAD;
        end
      end
      ST_GAP: begin
        gap_d   = gap_q + GAP_W'(1);
        state_d = (gap_q == GAP_W'(GAP_CYCLES - 1)) ? ST_IDLE : ST_GAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      null_q    <= 1'b0;
      null_en_q <= 1'b0;
      en_mask_q <= '1;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      give_q    <= '0;
      for (int s = 0; s < N_SRC; s++) begin
        for (int k = 0; k < HDR_LEN; k++) begin
          hdr_q[s*HDR_LEN + k] <= hdr_reset_byte(s, k);
        end
      end
      for (int k = 0; k < HDR_LEN; k++) begin
        shadow_q[k] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      null_q    <= null_d;
      null_en_q <= null_en_d;
      en_mask_q <= en_mask_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sync_q    <= sync_d;
      give_q    <= give_d;
      hdr_q     <= hdr_d;
      shadow_q  <= shadow_d;
    end
  end

  assign GIVE_ME_ONE_PACKET = give_q;
  assign DATA_OUT           = data_q;
  assign DCLK_OUT           = SYS_CLK;
  assign D_VALID_OUT        = valid_q;
  assign P_SYNC_OUT         = sync_q;

endmodule
